instr_fetch_unit: RTL and testbench

Instruction fetch stage between the program counter and decode. Consumes the PC's 32-bit instruction address stream and issues single-cycle synchronous reads to the 256-word instruction memory. Buffers returned words with their addresses in a small FIFO and hands them to decode over a valid/ready handshake. Back-pressures the PC with `fetch_stall` and flushes everything in flight when a branch is taken.

---
 rtl/instr_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch stage between the PC and decode. Issues single-cycle
//   synchronous reads to a 256-word instruction memory, buffers returned
//   words with their byte addresses in a small FIFO and presents them to
//   decode over a valid/ready handshake. Back-pressures the PC with
//   fetch_stall and flushes all in-flight work on a taken branch.
//
// Parameters
//   DEPTH      FIFO entries; occupancy accounting includes the outstanding read
//   LAST_ADDR  byte address of the final instruction word
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   ins_address   current PC byte address
//   branch_en     taken-branch strobe (flush)
//   fetch_stall   PC must hold ins_address while high (combinational)
//   imem_rd_en    instruction memory read strobe
//   imem_addr     word index, ins_address[9:2]
//   imem_rdata    read data, valid the cycle after imem_rd_en
//   dec_valid     FIFO head valid
//   dec_ready     decode accepts the head
//   dec_instr     head instruction word
//   dec_pc        head instruction byte address
//   program_done  LAST_ADDR fetched and fully drained
//   fetch_err     sticky bad-address flag (only with IF_ADDR_CHECK_EN)
//
// Build option
//   IF_ADDR_CHECK_EN  enables misaligned / out-of-range address checking
//                     and the fetch_err port.

module instr_fetch_unit #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] LAST_ADDR = 32'h3FC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins_address,
    input  logic        branch_en,
    output logic        fetch_stall,
    output logic        imem_rd_en,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        program_done
`ifdef IF_ADDR_CHECK_EN
    ,
    output logic        fetch_err
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    typedef enum logic {
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          inflight;
    logic [31:0]   tag;

    logic          pop, push;
    logic          attempt, issue, addr_bad;
    logic [OW-1:0] occ_after_pop;
    logic          occ_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign dec_valid = (count != '0);
    assign pop       = dec_valid & dec_ready;
    // A flush discards the outstanding read, so its data is never pushed.
    assign push      = inflight & ~branch_en;

    // Occupancy counts the outstanding read; a pop this cycle frees a slot.
    assign occ_after_pop = OW'(count) + OW'(inflight) - OW'(pop);
    assign occ_full      = (occ_after_pop >= OW'(DEPTH));

`ifdef IF_ADDR_CHECK_EN
    assign addr_bad = (ins_address[1:0] != 2'b00) || (ins_address > LAST_ADDR);
`else
    assign addr_bad = 1'b0;
`endif

    assign imem_addr    = ins_address[9:2];
    assign imem_rd_en   = issue;
    assign program_done = (state == S_DONE) & ~dec_valid & ~inflight;
    assign dec_instr    = dec_valid ? fifo_instr[rd_ptr] : '0;
    assign dec_pc       = dec_valid ? fifo_pc[rd_ptr]    : '0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and issue control
    always_comb begin
        state_nxt   = state;
        fetch_stall = 1'b0;
        attempt     = 1'b0;
        issue       = 1'b0;

        if (!reset && state == S_RUN && !branch_en) begin
            fetch_stall = occ_full;
            attempt     = ~occ_full;
            issue       = attempt & ~addr_bad;
        end

        if (branch_en) begin
            state_nxt = S_RUN;
        end else if (state == S_RUN) begin
            if (issue && ins_address[9:2] == LAST_ADDR[9:2]) begin
                state_nxt = S_DONE;
            end
            if (attempt && addr_bad) begin
                state_nxt = S_DONE;
            end
        end
    end

    // Outstanding read, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || branch_en) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                assert (count < CW'(DEPTH));
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag <= '0;
        end else if (issue) begin
            tag <= ins_address;
        end
    end

    // Storage needs no reset: the head is gated by dec_valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= tag;
        end
    end

`ifdef IF_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_err <= 1'b0;
        end else if (attempt && addr_bad) begin
            fetch_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. A behavioural instruction memory
//   answers reads one cycle later with a fixed word pattern; a PC model
//   advances by 4 on every issued read and loads the target on branch_en.
//   Checks cover reset values, streaming, back-pressure, flush, the end of
//   program and reset mid-stream (plus address checking when
//   IF_ADDR_CHECK_EN is defined).

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins_address;
    logic        branch_en;
    logic        fetch_stall;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        program_done;
`ifdef IF_ADDR_CHECK_EN
    logic        fetch_err;
`endif

    logic [31:0] br_target;
    int          checks = 0;
    int          errors = 0;

    instr_fetch_unit #(
        .DEPTH     (2),
        .LAST_ADDR (32'h3FC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ins_address  (ins_address),
        .branch_en    (branch_en),
        .fetch_stall  (fetch_stall),
        .imem_rd_en   (imem_rd_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_instr    (dec_instr),
        .dec_pc       (dec_pc),
        .program_done (program_done)
`ifdef IF_ADDR_CHECK_EN
        ,
        .fetch_err    (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] i);
        return {8'hC3, i, ~i, 8'h5A};
    endfunction

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the PC model advances on an issued read or loads the target.
    task automatic tick();
        logic issued;
        @(negedge clk);
        issued = imem_rd_en;
        @(posedge clk);
        #1;
        if (branch_en) ins_address = br_target;
        else if (issued) ins_address = ins_address + 32'd4;
    endtask

    initial begin
        reset       = 1'b1;
        branch_en   = 1'b0;
        dec_ready   = 1'b0;
        ins_address = '0;
        br_target   = '0;
        tick();
        tick();

        // Reset values
        check("rst_rd_en", imem_rd_en, 0);
        check("rst_stall", fetch_stall, 0);
        check("rst_valid", dec_valid, 0);
        check("rst_done", program_done, 0);
        check("rst_instr", dec_instr, 0);
        check("rst_pc", dec_pc, 0);
`ifdef IF_ADDR_CHECK_EN
        check("rst_err", fetch_err, 0);
`endif

        // Streaming with decode always ready
        reset     = 1'b0;
        dec_ready = 1'b1;
        #1;
        check("first_rd_en", imem_rd_en, 1);
        check("first_stall", fetch_stall, 0);
        check("first_addr", imem_addr, 0);
        tick();
        check("lat_valid_n1", dec_valid, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            check("str_valid", dec_valid, 1);
            check("str_pc", dec_pc, 32'(4 * k));
            check("str_instr", dec_instr, mem_word(8'(k)));
            tick();
        end

        // Back-pressure: head 0x20, 0x24 in flight
        dec_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", dec_valid, 1);
            check("bp_pc_hold", dec_pc, 32'h20);
            check("bp_stall", fetch_stall, 1);
            check("bp_rd_en", imem_rd_en, 0);
            tick();
        end
        dec_ready = 1'b1;
        #1;
        check("bp_release_stall", fetch_stall, 0);
        check("bp_release_addr", imem_addr, 8'h0A);
        for (int k = 0; k < 5; k++) begin
            check("bp_resume_pc", dec_pc, 32'(32'h20 + 4 * k));
            check("bp_resume_instr", dec_instr, mem_word(8'(8 + k)));
            tick();
        end

        // Flush: head 0x34, 0x38 in flight, branch to 0x40
        check("pre_br_pc", dec_pc, 32'h34);
        branch_en = 1'b1;
        br_target = 32'h40;
        #1;
        check("br_rd_en", imem_rd_en, 0);
        check("br_stall", fetch_stall, 0);
        tick();
        branch_en = 1'b0;
        #1;
        check("br_valid_n1", dec_valid, 0);
        check("br_issue", imem_rd_en, 1);
        check("br_addr", imem_addr, 8'h10);
        tick();
        check("br_valid_n2", dec_valid, 0);
        tick();
        check("br_tgt_valid", dec_valid, 1);
        check("br_tgt_pc", dec_pc, 32'h40);
        check("br_tgt_instr", dec_instr, mem_word(8'h10));

        // Back-to-back branches: only the last target is fetched
        branch_en = 1'b1;
        br_target = 32'h80;
        tick();
        br_target = 32'hC0;
        #1;
        check("bb_rd_en", imem_rd_en, 0);
        tick();
        branch_en = 1'b0;
        #1;
        check("bb_valid", dec_valid, 0);
        check("bb_addr", imem_addr, 8'h30);
        tick();
        tick();
        check("bb_pc", dec_pc, 32'hC0);

        // Run to the end of program
        branch_en = 1'b1;
        br_target = 32'h3F0;
        tick();
        branch_en = 1'b0;
        tick();
        tick();
        check("end_pc0", dec_pc, 32'h3F0);
        tick();
        check("end_pc1", dec_pc, 32'h3F4);
        check("end_last_issue", imem_rd_en, 1);
        check("end_last_addr", imem_addr, 8'hFF);
        tick();
        check("end_pc2", dec_pc, 32'h3F8);
        check("end_no_issue", imem_rd_en, 0);
        check("end_no_stall", fetch_stall, 0);
        check("end_not_done", program_done, 0);
        tick();
        check("end_pc3", dec_pc, 32'h3FC);
        check("end_instr3", dec_instr, mem_word(8'hFF));
        check("end_not_done2", program_done, 0);
        tick();
        check("end_empty", dec_valid, 0);
        check("end_done", program_done, 1);
        check("end_no_issue2", imem_rd_en, 0);
        tick();
        check("end_done_hold", program_done, 1);
        check("end_no_issue3", imem_rd_en, 0);

        // Branch out of DONE back to 0
        branch_en = 1'b1;
        br_target = 32'h0;
        tick();
        branch_en = 1'b0;
        #1;
        check("resume_rd_en", imem_rd_en, 1);
        check("resume_addr", imem_addr, 0);
        check("resume_not_done", program_done, 0);
        tick();
        tick();
        check("resume_pc", dec_pc, 32'h0);
        check("resume_instr", dec_instr, mem_word(8'h00));

        // Reset with head 0x0 held and 0x4 in flight
        reset = 1'b1;
        tick();
        check("mid_rst_valid", dec_valid, 0);
        check("mid_rst_pc", dec_pc, 0);
        check("mid_rst_instr", dec_instr, 0);
        check("mid_rst_rd_en", imem_rd_en, 0);
        check("mid_rst_stall", fetch_stall, 0);
        check("mid_rst_done", program_done, 0);
        reset       = 1'b0;
        ins_address = 32'h0;
        tick();
        check("post_rst_valid_n1", dec_valid, 0);
        tick();
        check("post_rst_pc", dec_pc, 32'h0);
        check("post_rst_instr", dec_instr, mem_word(8'h00));
        tick();
        check("post_rst_pc2", dec_pc, 32'h4);

`ifdef IF_ADDR_CHECK_EN
        // Misaligned / out-of-range address
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        ins_address = 32'h402;
        #1;
        check("err_no_issue", imem_rd_en, 0);
        check("err_pre", fetch_err, 0);
        tick();
        check("err_set", fetch_err, 1);
        check("err_no_issue2", imem_rd_en, 0);
        check("err_no_stall", fetch_stall, 0);
        tick();
        tick();
        check("err_sticky", fetch_err, 1);
        check("err_no_issue3", imem_rd_en, 0);
        reset = 1'b1;
        tick();
        check("err_cleared", fetch_err, 0);
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
